// File: rtl/mul_256b_seq.sv
// rtl/mul_256b_seq.sv - sequential 256x256->512 unsigned multiplier built on one 64x64 multiplier
// Limb pairs are issued one per cycle; partial products are shifted and accumulated into acc_q.

module mul_64b_wrapper #(
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  a_i,
  input  logic [63:0]  b_i,
  output logic [127:0] p_o
);
  logic [127:0] prod;
  assign prod = {64'd0, a_i} * {64'd0, b_i};

  generate
    if (MUL_LAT == 0) begin : g_comb
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst};
      assign p_o = prod;
    end else begin : g_pipe
      logic [127:0] pipe_q [MUL_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= prod;
          for (int k = 1; k < MUL_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end
      assign p_o = pipe_q[MUL_LAT-1];
    end
  endgenerate
endmodule

module mul_256b_seq #(
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_a,
  input  logic [255:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_p
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t       state_q, state_d;
  logic [255:0] a_q, b_q;
  logic [511:0] acc_q;
  logic [3:0]   cnt_q;
  logic [127:0] pp_q;
  logic [2:0]   pp_shift_q;
  logic         pp_vld_q;

  logic         idle_rdy, accept, issue_vld;
  logic [63:0]  mul_a, mul_b;
  logic [127:0] mul_p;
  logic [2:0]   issue_shift;
  logic         tag_out_vld, inflight;
  logic [2:0]   tag_out_shift;

  assign in_ready    = idle_rdy & ~rst;
  assign out_p       = acc_q;
  assign mul_a       = a_q[{cnt_q[3:2], 6'd0} +: 64];
  assign mul_b       = b_q[{cnt_q[1:0], 6'd0} +: 64];
  assign issue_shift = {1'b0, cnt_q[3:2]} + {1'b0, cnt_q[1:0]};

  mul_64b_wrapper #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .rst (rst),
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // Tag delay line tracks which wrapper outputs are real products and their limb shift.
  generate
    if (MUL_LAT == 0) begin : g_tag_comb
      assign tag_out_vld   = issue_vld;
      assign tag_out_shift = issue_shift;
      assign inflight      = 1'b0;
    end else begin : g_tag_pipe
      logic       tvld_q   [MUL_LAT];
      logic [2:0] tshift_q [MUL_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < MUL_LAT; k++) begin
            tvld_q[k]   <= 1'b0;
            tshift_q[k] <= '0;
          end
        end else begin
          tvld_q[0]   <= issue_vld;
          tshift_q[0] <= issue_shift;
          for (int k = 1; k < MUL_LAT; k++) begin
            tvld_q[k]   <= tvld_q[k-1];
            tshift_q[k] <= tshift_q[k-1];
          end
        end
      end
      always_comb begin
        inflight = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) inflight = inflight | tvld_q[k];
      end
      assign tag_out_vld   = tvld_q[MUL_LAT-1];
      assign tag_out_shift = tshift_q[MUL_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    idle_rdy  = 1'b0;
    out_valid = 1'b0;
    issue_vld = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        idle_rdy = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_vld = 1'b1;
        if (cnt_q == 4'd15) state_d = DRAIN;
      end
      // The last partial product is added on the same edge that enters DONE.
      DRAIN: if (pp_vld_q && !inflight) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pp_q       <= '0;
      pp_shift_q <= '0;
      pp_vld_q   <= 1'b0;
    end else begin
      pp_vld_q <= tag_out_vld;
      if (tag_out_vld) begin
        pp_q       <= mul_p;
        pp_shift_q <= tag_out_shift;
      end
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        if (issue_vld) cnt_q <= cnt_q + 4'd1;
        if (pp_vld_q)  acc_q <= acc_q + ({384'd0, pp_q} << {pp_shift_q, 6'd0});
      end
    end
  end
endmodule

// File: tb/tb_mul_256b_seq.sv
// tb/tb_mul_256b_seq.sv - directed and randomised checks of mul_256b_seq at MUL_LAT 0 and 3

module tb_mul_256b_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [255:0] in_a      [2];
  logic [255:0] in_b      [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [511:0] out_p     [2];

  int checks   = 0;
  int failures = 0;
  int lat_of [2] = '{0, 3};

  always #5 clk = ~clk;

  mul_256b_seq #(.MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0])
  );

  mul_256b_seq #(.MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1])
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Called at a negedge; leaves the bench at a negedge with the DUT back in IDLE.
  task automatic run_op(input int d, input logic [255:0] a, input logic [255:0] b,
                        input logic [511:0] exp, input int hold, input string tag);
    int  lat;
    int  wcnt;
    bit  ir_bad;
    wcnt = 0;
    while (!in_ready[d] && wcnt < 100) begin
      @(negedge clk);
      wcnt++;
    end
    check({tag, "_rdy"}, 512'(in_ready[d]), 512'd1);
    in_valid[d] = 1'b1;
    in_a[d]     = a;
    in_b[d]     = b;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_a[d]     = ~a;
    in_b[d]     = ~b;
    lat    = 0;
    ir_bad = 1'b0;
    do begin
      @(negedge clk);
      if (!out_valid[d] && in_ready[d]) ir_bad = 1'b1;
      if (!out_valid[d]) begin
        @(posedge clk);
        lat++;
      end
    end while (!out_valid[d] && lat < 200);
    check({tag, "_lat"}, 512'(lat), 512'(17 + lat_of[d]));
    check({tag, "_p"}, out_p[d], exp);
    check({tag, "_rdy_busy"}, 512'(ir_bad), 512'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_v"}, 512'(out_valid[d]), 512'd1);
      check({tag, "_hold_p"}, out_p[d], exp);
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    check({tag, "_post_v"}, 512'(out_valid[d]), 512'd0);
    check({tag, "_post_rdy"}, 512'(in_ready[d]), 512'd1);
    check({tag, "_post_p"}, out_p[d], exp);
  endtask

  initial begin
    logic [255:0] ra, rb;
    logic [511:0] full_exp;
    bit           seen;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_a[d]      = '0;
      in_b[d]      = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_rdy", 512'(in_ready[0]), 512'd0);
    check("rst_ov", 512'(out_valid[0]), 512'd0);
    check("rst_p", out_p[0], 512'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_rdy0", 512'(in_ready[0]), 512'd1);
    check("rel_rdy3", 512'(in_ready[1]), 512'd1);

    run_op(0, 256'd0, 256'd0, 512'd0, 0, "zero");
    run_op(0, 256'd1, 256'd1 << 255, 512'd1 << 255, 0, "a1_b2p255");
    run_op(0, 256'd1 << 64, 256'd1 << 64, 512'd1 << 128, 0, "b64x64");
    run_op(0, 256'd1 << 192, 256'd1 << 192, 512'd1 << 384, 0, "top_limbs");
    full_exp = {{255{1'b1}}, 256'd0, 1'b1};
    run_op(0, {256{1'b1}}, {256{1'b1}}, full_exp, 0, "all_ones");
    run_op(0, 256'd7, 256'd9, 512'd63, 5, "backpressure");
    run_op(1, {256{1'b1}}, {256{1'b1}}, full_exp, 2, "all_ones_l3");

    in_valid[0] = 1'b1;
    in_a[0]     = {256{1'b1}};
    in_b[0]     = {256{1'b1}};
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort_rdy", 512'(in_ready[0]), 512'd0);
    check("abort_ov", 512'(out_valid[0]), 512'd0);
    check("abort_p", out_p[0], 512'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("abort_no_ov", 512'(seen), 512'd0);
    run_op(0, 256'd3, 256'd5, 512'd15, 0, "after_abort");

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        ra = rnd256();
        rb = rnd256();
        run_op(d, ra, rb, {256'd0, ra} * {256'd0, rb}, 0, (d == 0) ? "rnd_l0" : "rnd_l3");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
